// File: rtl/keypad_entry.sv
// Keypad digit entry and operand sequencing for the calculator: synchronizes keys/buttons,
// builds two decimal operands and hands them off via calc_req/calc_ack. Optional: KEYPAD_ENTRY_BACKSPACE_EN.
module keypad_entry #(
    parameter int MAX_DIGITS = 6,
    parameter int VAL_W      = 20,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      keypad_decode,
    input  logic             bttn_eq_n,
    input  logic             bttn_clr_n,
    input  logic             calc_ack,
    input  logic [VAL_W-1:0] calc_result,
    output logic [VAL_W-1:0] operand_a,
    output logic [VAL_W-1:0] operand_b,
    output logic             calc_req,
    output logic [VAL_W-1:0] hex_disp,
    output logic [CNT_W-1:0] digit_cnt,
    output logic             entry_full,
    output logic [1:0]       state_place
);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_RES = 2'd2,
        SHOW_RES = 2'd3
    } state_t;

    // Handshake: calc_req rises when operands are final and holds (operands stable)
    // until calc_ack is sampled high in WAIT_RES; the ack cycle itself completes the transfer.

    logic [15:0]      kp_s1_q, kp_s2_q;
    logic             kp_idle_q;
    logic             eq_s1_q, eq_s2_q, eq_s3_q;
    logic             clr_s1_q, clr_s2_q, clr_s3_q;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] operand_a_q, operand_a_d;
    logic [VAL_W-1:0] operand_b_q, operand_b_d;
    logic [VAL_W-1:0] hex_disp_q, hex_disp_d;
    logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;
    logic             entry_full_q, entry_full_d;
    logic             calc_req_q, calc_req_d;

    logic             kp_onehot;
    logic             key_evt, eq_evt, clr_evt;
    logic [3:0]       key_idx;
    logic             is_digit, is_next;
    logic [VAL_W-1:0] cur_op, op_x10;
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    logic             is_bksp;
    logic [VAL_W-1:0] op_div10;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_s1_q   <= '0;
            kp_s2_q   <= '0;
            kp_idle_q <= 1'b1;
            eq_s1_q   <= 1'b1;
            eq_s2_q   <= 1'b1;
            eq_s3_q   <= 1'b1;
            clr_s1_q  <= 1'b1;
            clr_s2_q  <= 1'b1;
            clr_s3_q  <= 1'b1;
        end else begin
            kp_s1_q   <= keypad_decode;
            kp_s2_q   <= kp_s1_q;
            kp_idle_q <= (kp_s2_q == '0);
            eq_s1_q   <= bttn_eq_n;
            eq_s2_q   <= eq_s1_q;
            eq_s3_q   <= eq_s2_q;
            clr_s1_q  <= bttn_clr_n;
            clr_s2_q  <= clr_s1_q;
            clr_s3_q  <= clr_s2_q;
        end
    end

    // A key only counts on the transition out of all-released into a single key.
    assign kp_onehot = (kp_s2_q != '0) && ((kp_s2_q & (kp_s2_q - 16'd1)) == '0);
    assign key_evt   = kp_idle_q && kp_onehot;
    assign eq_evt    = eq_s3_q && !eq_s2_q;
    assign clr_evt   = clr_s3_q && !clr_s2_q;

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (kp_s2_q[i]) key_idx = 4'(i);
        end
    end

    assign is_digit = key_evt && (key_idx <= 4'd9);
    assign is_next  = key_evt && (key_idx == 4'd11);
    assign cur_op   = (state_q == ENTER_B) ? operand_b_q : operand_a_q;
    assign op_x10   = (cur_op << 3) + (cur_op << 1) + VAL_W'(key_idx);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    assign is_bksp  = key_evt && (key_idx == 4'd10);
    assign op_div10 = cur_op / VAL_W'(10);
`endif

    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        hex_disp_d  = hex_disp_q;
        digit_cnt_d = digit_cnt_q;
        calc_req_d  = calc_req_q;
        if (clr_evt) begin
            state_d     = ENTER_A;
            operand_a_d = '0;
            operand_b_d = '0;
            hex_disp_d  = '0;
            digit_cnt_d = '0;
            calc_req_d  = 1'b0;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (eq_evt && state_q == ENTER_B) begin
                        state_d    = WAIT_RES;
                        calc_req_d = 1'b1;
                    end else if (is_digit && digit_cnt_q < CNT_W'(MAX_DIGITS)) begin
                        if (state_q == ENTER_B) operand_b_d = op_x10;
                        else                    operand_a_d = op_x10;
                        hex_disp_d  = op_x10;
                        digit_cnt_d = digit_cnt_q + 1'b1;
                    end else if (is_next && state_q == ENTER_A) begin
                        state_d     = ENTER_B;
                        operand_b_d = '0;
                        hex_disp_d  = '0;
                        digit_cnt_d = '0;
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                    end else if (is_bksp && digit_cnt_q != '0) begin
                        if (state_q == ENTER_B) operand_b_d = op_div10;
                        else                    operand_a_d = op_div10;
                        hex_disp_d  = op_div10;
                        digit_cnt_d = digit_cnt_q - 1'b1;
`endif
                    end
                end
                WAIT_RES: begin
                    if (calc_ack) begin
                        hex_disp_d = calc_result;
                        calc_req_d = 1'b0;
                        state_d    = SHOW_RES;
                    end
                end
                SHOW_RES: begin
                    if (is_digit) begin
                        state_d     = ENTER_A;
                        operand_a_d = VAL_W'(key_idx);
                        operand_b_d = '0;
                        hex_disp_d  = VAL_W'(key_idx);
                        digit_cnt_d = CNT_W'(1);
                    end else if (is_next) begin
                        state_d     = ENTER_B;
                        operand_a_d = hex_disp_q;
                        operand_b_d = '0;
                        digit_cnt_d = '0;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
        entry_full_d = (digit_cnt_d == CNT_W'(MAX_DIGITS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ENTER_A;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            hex_disp_q   <= '0;
            digit_cnt_q  <= '0;
            entry_full_q <= 1'b0;
            calc_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            hex_disp_q   <= hex_disp_d;
            digit_cnt_q  <= digit_cnt_d;
            entry_full_q <= entry_full_d;
            calc_req_q   <= calc_req_d;
        end
    end

    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign hex_disp    = hex_disp_q;
    assign digit_cnt   = digit_cnt_q;
    assign entry_full  = entry_full_q;
    assign calc_req    = calc_req_q;
    assign state_place = state_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: digit entry, latency, limits, handshake, chaining and clear.
module tb_keypad_entry;

    localparam int VAL_W = 20;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      keypad_decode = '0;
    logic             bttn_eq_n = 1'b1;
    logic             bttn_clr_n = 1'b1;
    logic             calc_ack = 1'b0;
    logic [VAL_W-1:0] calc_result = '0;
    logic [VAL_W-1:0] operand_a, operand_b, hex_disp;
    logic             calc_req, entry_full;
    logic [CNT_W-1:0] digit_cnt;
    logic [1:0]       state_place;

    int checks = 0;
    int failures = 0;

    keypad_entry dut (
        .clk(clk), .rst(rst), .keypad_decode(keypad_decode),
        .bttn_eq_n(bttn_eq_n), .bttn_clr_n(bttn_clr_n),
        .calc_ack(calc_ack), .calc_result(calc_result),
        .operand_a(operand_a), .operand_b(operand_b), .calc_req(calc_req),
        .hex_disp(hex_disp), .digit_cnt(digit_cnt), .entry_full(entry_full),
        .state_place(state_place)
    );

    always #5 clk = ~clk;

    task automatic press_key(input int idx);
        keypad_decode = 16'(1) << idx;
        repeat (4) @(negedge clk);
        keypad_decode = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_eq();
        bttn_eq_n = 1'b0;
        repeat (4) @(negedge clk);
        bttn_eq_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_clr();
        bttn_clr_n = 1'b0;
        repeat (4) @(negedge clk);
        bttn_clr_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_ack(input logic [VAL_W-1:0] r);
        calc_result = r;
        calc_ack = 1'b1;
        @(negedge clk);
        calc_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (operand_a !== 20'd0) begin failures++; $display("FAIL rst_operand_a got=%0d exp=0", operand_a); end
        checks++; if (operand_b !== 20'd0) begin failures++; $display("FAIL rst_operand_b got=%0d exp=0", operand_b); end
        checks++; if (hex_disp !== 20'd0) begin failures++; $display("FAIL rst_hex_disp got=%0d exp=0", hex_disp); end
        checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL rst_digit_cnt got=%0d exp=0", digit_cnt); end
        checks++; if (entry_full !== 1'b0) begin failures++; $display("FAIL rst_entry_full got=%0b exp=0", entry_full); end
        checks++; if (calc_req !== 1'b0) begin failures++; $display("FAIL rst_calc_req got=%0b exp=0", calc_req); end
        checks++; if (state_place !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_place); end
    endtask

    task automatic test_digit_entry();
        keypad_decode = 16'(1) << 1;
        repeat (2) @(negedge clk);
        checks++; if (hex_disp !== 20'd0) begin failures++; $display("FAIL latency_early got=%0d exp=0", hex_disp); end
        @(negedge clk);
        checks++; if (hex_disp !== 20'd1) begin failures++; $display("FAIL latency_third_edge got=%0d exp=1", hex_disp); end
        @(negedge clk);
        keypad_decode = '0;
        repeat (4) @(negedge clk);
        press_key(2);
        press_key(3);
        checks++; if (hex_disp !== 20'd123) begin failures++; $display("FAIL entry_hex got=%0d exp=123", hex_disp); end
        checks++; if (operand_a !== 20'd123) begin failures++; $display("FAIL entry_operand_a got=%0d exp=123", operand_a); end
        checks++; if (digit_cnt !== 3'd3) begin failures++; $display("FAIL entry_cnt got=%0d exp=3", digit_cnt); end
        checks++; if (state_place !== 2'd0) begin failures++; $display("FAIL entry_state got=%0d exp=0", state_place); end
    endtask

    task automatic test_full_and_calc();
        press_clr();
        checks++; if (hex_disp !== 20'd0) begin failures++; $display("FAIL clr_hex got=%0d exp=0", hex_disp); end
        for (int i = 0; i < 7; i++) press_key(9);
        checks++; if (operand_a !== 20'd999999) begin failures++; $display("FAIL full_operand_a got=%0d exp=999999", operand_a); end
        checks++; if (digit_cnt !== 3'd6) begin failures++; $display("FAIL full_cnt got=%0d exp=6", digit_cnt); end
        checks++; if (entry_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", entry_full); end
        press_key(11);
        checks++; if (state_place !== 2'd1) begin failures++; $display("FAIL next_state got=%0d exp=1", state_place); end
        checks++; if (entry_full !== 1'b0 || digit_cnt !== 3'd0 || hex_disp !== 20'd0)
            begin failures++; $display("FAIL next_reset got=full%0b/cnt%0d/hex%0d exp=0/0/0", entry_full, digit_cnt, hex_disp); end
        press_key(11);
        checks++; if (state_place !== 2'd1) begin failures++; $display("FAIL next_in_b got=%0d exp=1", state_place); end
        press_key(4);
        press_key(5);
        checks++; if (operand_b !== 20'd45) begin failures++; $display("FAIL operand_b got=%0d exp=45", operand_b); end
        press_eq();
        checks++; if (calc_req !== 1'b1 || state_place !== 2'd2)
            begin failures++; $display("FAIL eq_req got=req%0b/st%0d exp=1/2", calc_req, state_place); end
        press_key(7);
        checks++; if (operand_b !== 20'd45 || calc_req !== 1'b1)
            begin failures++; $display("FAIL wait_key_ignored got=b%0d/req%0b exp=45/1", operand_b, calc_req); end
        send_ack(20'd1000044);
        checks++; if (hex_disp !== 20'd1000044) begin failures++; $display("FAIL ack_hex got=%0d exp=1000044", hex_disp); end
        checks++; if (state_place !== 2'd3 || calc_req !== 1'b0)
            begin failures++; $display("FAIL ack_state got=st%0d/req%0b exp=3/0", state_place, calc_req); end
    endtask

    task automatic test_show_res_chain();
        press_clr();
        press_key(2); press_key(5); press_key(11); press_key(2); press_key(5);
        press_eq();
        send_ack(20'd50);
        press_key(11);
        checks++; if (state_place !== 2'd1 || operand_a !== 20'd50 || operand_b !== 20'd0)
            begin failures++; $display("FAIL chain got=st%0d/a%0d/b%0d exp=1/50/0", state_place, operand_a, operand_b); end
        press_key(7);
        press_eq();
        checks++; if (calc_req !== 1'b1 || operand_a !== 20'd50 || operand_b !== 20'd7)
            begin failures++; $display("FAIL chain_req got=req%0b/a%0d/b%0d exp=1/50/7", calc_req, operand_a, operand_b); end
        send_ack(20'd57);
        press_key(3);
        checks++; if (operand_a !== 20'd3 || state_place !== 2'd0 || digit_cnt !== 3'd1 || operand_b !== 20'd0)
            begin failures++; $display("FAIL new_entry got=a%0d/st%0d/cnt%0d/b%0d exp=3/0/1/0", operand_a, state_place, digit_cnt, operand_b); end
    endtask

    task automatic test_multibit_hold();
        press_clr();
        keypad_decode = 16'b0000_0000_0000_0110;
        repeat (6) @(negedge clk);
        keypad_decode = '0;
        repeat (4) @(negedge clk);
        checks++; if (hex_disp !== 20'd0 || digit_cnt !== 3'd0)
            begin failures++; $display("FAIL multibit got=hex%0d/cnt%0d exp=0/0", hex_disp, digit_cnt); end
        keypad_decode = 16'(1) << 2;
        repeat (10) @(negedge clk);
        keypad_decode = '0;
        repeat (4) @(negedge clk);
        checks++; if (hex_disp !== 20'd2 || digit_cnt !== 3'd1)
            begin failures++; $display("FAIL held_key got=hex%0d/cnt%0d exp=2/1", hex_disp, digit_cnt); end
        press_key(13);
        checks++; if (hex_disp !== 20'd2 || digit_cnt !== 3'd1)
            begin failures++; $display("FAIL key13_ignored got=hex%0d/cnt%0d exp=2/1", hex_disp, digit_cnt); end
        press_eq();
        checks++; if (state_place !== 2'd0 || calc_req !== 1'b0)
            begin failures++; $display("FAIL eq_in_a got=st%0d/req%0b exp=0/0", state_place, calc_req); end
    endtask

    task automatic test_clear_priority();
        press_clr();
        press_key(8); press_key(11); press_key(9);
        bttn_eq_n = 1'b0;
        bttn_clr_n = 1'b0;
        repeat (4) @(negedge clk);
        bttn_eq_n = 1'b1;
        bttn_clr_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (state_place !== 2'd0 || calc_req !== 1'b0)
            begin failures++; $display("FAIL clr_wins got=st%0d/req%0b exp=0/0", state_place, calc_req); end
        checks++; if (operand_a !== 20'd0 || operand_b !== 20'd0 || hex_disp !== 20'd0 || digit_cnt !== 3'd0)
            begin failures++; $display("FAIL clr_values got=a%0d/b%0d/hex%0d/cnt%0d exp=0", operand_a, operand_b, hex_disp, digit_cnt); end
        press_key(1); press_key(11); press_key(2);
        press_eq();
        checks++; if (state_place !== 2'd2) begin failures++; $display("FAIL wait_entry got=%0d exp=2", state_place); end
        press_clr();
        send_ack(20'd77);
        checks++; if (hex_disp !== 20'd0 || state_place !== 2'd0 || calc_req !== 1'b0)
            begin failures++; $display("FAIL late_ack got=hex%0d/st%0d/req%0b exp=0/0/0", hex_disp, state_place, calc_req); end
    endtask

    task automatic test_backspace();
        logic [VAL_W-1:0] exp_hex;
        logic [CNT_W-1:0] exp_cnt;
        press_clr();
        press_key(4); press_key(5); press_key(6);
        press_key(10);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
        exp_hex = 20'd45;
        exp_cnt = 3'd2;
`else
        exp_hex = 20'd456;
        exp_cnt = 3'd3;
`endif
        checks++; if (hex_disp !== exp_hex || digit_cnt !== exp_cnt)
            begin failures++; $display("FAIL backspace got=hex%0d/cnt%0d exp=%0d/%0d", hex_disp, digit_cnt, exp_hex, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_full_and_calc();
        test_show_res_chain();
        test_multibit_hold();
        test_clear_priority();
        test_backspace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Synchronous keypad digit-entry and operand-sequencing block for the DE10-lite calculator. It sits between the one-hot keypad decoder / push-buttons and the arithmetic unit. It accumulates decimal digits into two operands and hands them to the calculator with a req/ack handshake. It also drives the value shown on the 7-segment display path. It supersedes the level-sensitive entry logic with one clocked design, parametrised in width and digit count.

## Interface
Parameters:
- MAX_DIGITS, 6, maximum decimal digits per operand; must satisfy 10^MAX_DIGITS − 1 < 2^VAL_W
- VAL_W, 20, width of operands, result and display value
- CNT_W, $clog2(MAX_DIGITS+1), width of digit counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- keypad_decode  in  16  one-hot key level from decoder; bits 0–9 = digits, bit 10 = backspace, bit 11 = next-operand
- bttn_eq_n  in  1  equals button, active-low, asynchronous
- bttn_clr_n  in  1  clear button, active-low, asynchronous
- calc_ack  in  1  calculator result valid
- calc_result  in  VAL_W  calculator result, sampled when calc_ack=1 in WAIT_RES
- operand_a  out  VAL_W  first operand
- operand_b  out  VAL_W  second operand
- calc_req  out  1  request to calculator
- hex_disp  out  VAL_W  binary value for display
- digit_cnt  out  CNT_W  digits entered in current operand
- entry_full  out  1  digit_cnt == MAX_DIGITS
- state_place  out  2  FSM state: 0 ENTER_A, 1 ENTER_B, 2 WAIT_RES, 3 SHOW_RES

## Operation
- keypad_decode, bttn_eq_n and bttn_clr_n each pass through a 2-flop synchronizer.
- Key press event: the synced keypad goes from all-zero to exactly one bit set. Multi-bit patterns are ignored. No further event is accepted until the synced keypad returns to all-zero.
- Button events fire on the synced falling edge only.
- Priority within one cycle: clear > equals > key.
- Clear (any state): operand_a = operand_b = hex_disp = 0, digit_cnt = 0, calc_req = 0, go to ENTER_A. If clear occurs in WAIT_RES, the request is aborted and a late calc_ack is ignored.
- Digit d in ENTER_A/ENTER_B with digit_cnt < MAX_DIGITS: the current operand becomes operand×10 + d, truncated to VAL_W. digit_cnt increments and hex_disp shows the operand. Digits at MAX_DIGITS are dropped with no change.
- Key 11 in ENTER_A: go to ENTER_B, digit_cnt = 0, operand_b = 0, hex_disp = 0.
- Key 11 in ENTER_B: ignored.
- Equals in ENTER_B: go to WAIT_RES and raise calc_req.
- Equals in ENTER_A, WAIT_RES or SHOW_RES: ignored.
- WAIT_RES: calc_req stays high until calc_ack. On the ack cycle, hex_disp ← calc_result, calc_req falls and the FSM goes to SHOW_RES. Keys are ignored in WAIT_RES.
- SHOW_RES, digit d: start a new entry. operand_a = d, operand_b = 0, digit_cnt = 1, go to ENTER_A.
- SHOW_RES, key 11: chain. operand_a ← result, operand_b = 0, digit_cnt = 0, go to ENTER_B.
- Keys 12–15 are always ignored.

## Timing
- Reset values: operand_a, operand_b, hex_disp = 0; digit_cnt = 0; entry_full = 0; calc_req = 0; state_place = 0 (ENTER_A); synchronizers cleared to idle (keypad 0, buttons 1).
- Raw key or button change → registered effect visible after the 3rd rising clk edge.
- calc_req asserts on the same edge that enters WAIT_RES.
- calc_ack sampled high → calc_req low and hex_disp updated on that same edge.
- A zero-latency ack in the first WAIT_RES cycle is legal.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- KEYPAD_ENTRY_BACKSPACE_EN defined: key 10 in ENTER_A/ENTER_B with digit_cnt > 0 sets operand ← operand/10 and decrements digit_cnt; hex_disp follows. With digit_cnt = 0 it has no effect.
- KEYPAD_ENTRY_BACKSPACE_EN undefined: key 10 is ignored like keys 12–15, and no divider is synthesised.

## Test plan
- Reset, then keys 1,2,3 with release between each → hex_disp = 123, digit_cnt = 3, state_place = 0; each update lands 3 edges after the raw press.
- Seven digits 9 in ENTER_A → operand_a = 999999, entry_full = 1, 7th digit dropped; key 11, keys 4,5, equals → calc_req = 1 with operand_b = 45; ack with calc_result = 1000044 → hex_disp = 1000044, state_place = 3, calc_req = 0.
- Key bits 1 and 2 set together, then key 2 held across 10 cycles → no update for the pair; single increment for the held key.
- Equals and clear falling in the same cycle during ENTER_B → clear wins: state 0, all values 0, calc_req = 0. Clear in WAIT_RES followed by calc_ack → ack ignored, hex_disp = 0.
- SHOW_RES with result 50, key 11, key 7, equals → calc_req with operand_a = 50, operand_b = 7; in SHOW_RES, key 3 → operand_a = 3, state 0.
- With KEYPAD_ENTRY_BACKSPACE_EN: enter 456, key 10 → hex_disp = 45, digit_cnt = 2. Without it: key 10 → hex_disp stays 456.
